// File: rtl/xs3_digit_sequencer.sv
// Packed binary/BCD to Excess-3 converter: one shared 4-bit adder walks the digits serially.
// Optional build macro XS3_BCD_CHECK_EN adds out_err, flagging any input digit above 9.
module xs3_digit_sequencer #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  busy,
  output logic [2:0]            digit_idx
`ifdef XS3_BCD_CHECK_EN
  ,
  output logic                  out_err
`endif
);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  localparam logic [2:0] LastIdx = 3'(DIGITS - 1);

  state_e              state_q;
  logic [4*DIGITS-1:0] in_q;
  logic [4*DIGITS-1:0] out_q;
  logic [2:0]          idx_q;
  logic [3:0]          cur_digit;
  logic [3:0]          cur_xs3;
`ifdef XS3_BCD_CHECK_EN
  logic                err_q;
`endif

  // Select the digit under conversion; idx_q never exceeds DIGITS-1.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == i[2:0]) cur_digit = in_q[4*i +: 4];
    end
  end

  // The single shared converter; carry out of bit 3 is dropped.
  assign cur_xs3 = cur_digit + 4'b0011;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      in_q    <= '0;
      out_q   <= '0;
      idx_q   <= '0;
`ifdef XS3_BCD_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            in_q    <= in_data;
            out_q   <= '0;
            idx_q   <= '0;
`ifdef XS3_BCD_CHECK_EN
            err_q   <= 1'b0;
`endif
            state_q <= StConv;
          end
        end
        StConv: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == i[2:0]) out_q[4*i +: 4] <= cur_xs3;
          end
`ifdef XS3_BCD_CHECK_EN
          err_q <= err_q | (cur_digit > 4'd9);
`endif
          if (idx_q == LastIdx) begin
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + 3'd1;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign digit_idx = idx_q;
  assign out_data  = out_q;
`ifdef XS3_BCD_CHECK_EN
  assign out_err   = err_q;
`endif

endmodule

// File: tb/tb_xs3_digit_sequencer.sv
// Directed self-checking bench for xs3_digit_sequencer (DIGITS = 4).
// Cycle k after accept is the k-th falling edge following the accepting rising edge.
module tb_xs3_digit_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;
  logic [2:0]  digit_idx;
`ifdef XS3_BCD_CHECK_EN
  logic        out_err;
`endif

  int errors = 0;
  int checks = 0;

  xs3_digit_sequencer #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .digit_idx (digit_idx)
`ifdef XS3_BCD_CHECK_EN
    ,
    .out_err   (out_err)
`endif
  );

  always #5 clk = ~clk;

  // Waits for out_valid on falling edges; lat=0 means it never came within the budget.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL rst_digit_idx got=%0d exp=0", digit_idx); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data got=%h exp=0000", out_data); end
    // Release with a word already offered: it must be taken on the first rising edge.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0000; out_ready = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_first_accept busy got=%b exp=1", busy); end
    in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL rst_first_latency got=%0d exp=4", lat); end
    checks++; if (out_data !== 16'h3333) begin errors++; $display("FAIL rst_first_data got=%h exp=3333", out_data); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = 16'hFFFF;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
      checks++;
      if (digit_idx !== 3'(k - 1) || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_conv cyc=%0d idx=%0d exp=%0d in_ready=%b busy=%b", k, digit_idx, k - 1,
                 in_ready, busy);
      end
    end
    checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    checks++; if (out_data !== 16'h4567) begin errors++; $display("FAIL basic_data got=%h exp=4567", out_data); end
    checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL basic_idx_wrap got=%0d exp=0", digit_idx); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_back_idle got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    logic [15:0] res [2];
    int nacc = 0;
    int nres = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h9999; out_ready = 1'b1;
    for (int n = 0; n < 30 && nres < 2; n++) begin
      if (n > 0) @(negedge clk);
      if (out_valid) begin res[nres] = out_data; nres++; end
      if (nacc == 2) in_valid = 1'b0;
      if (in_ready && in_valid && nacc < 2) begin
        acc[nacc] = n; nacc++;
      end else if (nacc == 1) begin
        in_data = 16'h0000;
      end
    end
    in_valid = 1'b0;
    checks++; if (nacc != 2 || nres != 2) begin errors++; $display("FAIL b2b_count acc=%0d res=%0d exp=2/2", nacc, nres); end
    checks++; if (nacc == 2 && acc[1] - acc[0] != 6) begin errors++; $display("FAIL b2b_spacing got=%0d exp=6", acc[1] - acc[0]); end
    checks++; if (nres > 0 && res[0] !== 16'hCCCC) begin errors++; $display("FAIL b2b_first got=%h exp=cccc", res[0]); end
    checks++; if (nres > 1 && res[1] !== 16'h3333) begin errors++; $display("FAIL b2b_second got=%h exp=3333", res[1]); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0580; out_ready = 1'b0;
    @(posedge clk);
    #1 in_data = 16'hAAAA;  // keep offering a different word; it must be ignored
    wait_valid(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL bp_latency got=%0d exp=5", lat); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'h38B3) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d valid=%b in_ready=%b data=%h exp=1/0/38b3", k, out_valid,
                 in_ready, out_data);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
  endtask

  task automatic test_wrap();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hFEDC; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
    checks++; if (out_data !== 16'h210F) begin errors++; $display("FAIL wrap_data got=%h exp=210f", out_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h4321; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || digit_idx !== 3'd0 ||
        out_data !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_outputs rdy=%b vld=%b busy=%b idx=%0d data=%h exp=1/0/0/0/0000",
               in_ready, out_valid, busy, digit_idx, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_no_valid got=1 exp=0"); end
    in_valid = 1'b1; in_data = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
    checks++; if (out_data !== 16'h3334) begin errors++; $display("FAIL midrst_next_data got=%h exp=3334", out_data); end
    @(negedge clk);
  endtask

`ifdef XS3_BCD_CHECK_EN
  task automatic test_bcd_check();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h12A4; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (out_data !== 16'h45D7) begin errors++; $display("FAIL bcd_bad_data got=%h exp=45d7", out_data); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL bcd_bad_err got=%b exp=1", out_err); end
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (out_data !== 16'h4567) begin errors++; $display("FAIL bcd_good_data got=%h exp=4567", out_data); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL bcd_good_err got=%b exp=0", out_err); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef XS3_BCD_CHECK_EN
    test_bcd_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xs3_digit_sequencer.md
XS3_DIGIT_SEQUENCER -- requirements
Module: xs3_digit_sequencer

Interface
REQ-001 Parameter: DIGITS, default 4, number of 4-bit digits per word (legal range 1..8).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  input  1  in_data holds a word to convert.
REQ-005 Port: in_ready  output  1  block can accept a word this cycle.
REQ-006 Port: in_data  input  4*DIGITS  packed binary/BCD digits, digit 0 in bits [3:0].
REQ-007 Port: out_valid  output  1  out_data holds a finished Excess-3 word.
REQ-008 Port: out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 Port: out_data  output  4*DIGITS  packed Excess-3 digits, same ordering as in_data.
REQ-010 Port: busy  output  1  high while state is not IDLE.
REQ-011 Port: digit_idx  output  3  index of the digit currently being converted; 0 outside CONV.

Function
REQ-012 The block SHALL contain exactly one shared 4-bit digit converter (digit + 4'b0011), time-multiplexed across all digits.
REQ-013 Converter arithmetic SHALL be 4-bit modulo-16 with the carry discarded (e.g. 4'hD -> 4'h0, 4'hF -> 4'h2).
REQ-014 FSM states SHALL be IDLE, CONV, DONE; no other reachable states.
REQ-015 IDLE: in_ready=1; on in_valid=1, latch in_data, clear out_data, set digit_idx=0, go to CONV.
REQ-016 CONV: each cycle convert digit digit_idx into its out_data slot, then increment digit_idx; after digit DIGITS-1 go to DONE.
REQ-017 Latency: out_valid SHALL rise exactly DIGITS+1 cycles after the accepting edge (DIGITS=4 -> 5 cycles).
REQ-018 DONE: out_valid=1 and out_data held stable until the cycle with out_ready=1, then return to IDLE.
REQ-019 in_ready SHALL be 0 in CONV and DONE; in_data changes there are ignored.
REQ-020 The cycle DONE exits with out_ready=1, in_ready remains 0; a new word is accepted no earlier than the following cycle (max throughput one word per DIGITS+2 cycles).
REQ-021 out_ready while not in DONE SHALL have no effect.
REQ-022 digit_idx SHALL wrap to 0 on leaving CONV; it never exceeds DIGITS-1.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, in_ready=1, out_valid=0, busy=0, digit_idx=0, out_data=0, and any error flag to 0.
REQ-024 Reset asserted mid-CONV or in DONE SHALL discard the word in flight; no out_valid pulse follows reset release.
REQ-025 First accept after reset release SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro XS3_BCD_CHECK_EN, when defined, SHALL add output port out_err (1 bit), valid with out_valid, set if any input digit exceeded 4'h9.
REQ-027 With XS3_BCD_CHECK_EN, out_err SHALL be cleared on accept and held with out_data in DONE; out_data is still produced per REQ-013.
REQ-028 Without XS3_BCD_CHECK_EN, port out_err and its logic SHALL not exist; all other behaviour unchanged.

Verification
REQ-029 DIGITS=4, in_data=16'h1234 accepted, out_ready=1 -> out_data=16'h4567, out_valid on cycle 5 after accept, one cycle only.
REQ-030 in_data=16'h9999 then 16'h0000 back-to-back -> 16'hCCCC then 16'h3333; second accept no earlier than 6 cycles after first.
REQ-031 Backpressure: in_data=16'h0580, out_ready=0 for 10 cycles -> out_data=16'h38B3 stable, in_ready=0 throughout, released on out_ready=1.
REQ-032 Wrap: in_data=16'hFEDC -> out_data=16'h210F.
REQ-033 Reset: rst_n low at cycle 2 of CONV for 16'h4321 -> all outputs at reset values, no out_valid; next word 16'h0001 -> 16'h3334.
REQ-034 XS3_BCD_CHECK_EN defined: in_data=16'h12A4 -> out_data=16'h45D7, out_err=1; 16'h1234 -> out_err=0.
